spi_slave_shifter: RTL

SPI slave serial/parallel shift stage (mode 0: CPOL=0, CPHA=0, MSB first). Consumes the single-cycle SCLK and CS edge pulses produced by the edge-detect comparators in the SPI slave driver, together with synchronized MOSI. Assembles received words and presents them with a one-cycle valid strobe. Serializes transmit words from a one-entry buffer onto MISO.

---
 rtl/spi_slave_shifter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/spi_slave_shifter.sv
// SPI mode-0 slave shift stage: assembles MOSI words, serializes a one-entry
// TX buffer onto MISO, driven by pre-detected SCLK/CS edge pulses.
module spi_slave_shifter #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] IDLE_WORD = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sclk_pos,
  input  logic             sclk_neg,
  input  logic             cs_fall,
  input  logic             cs_rise,
  input  logic             mosi,
  output logic             miso,
  output logic             miso_oe,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             tx_underrun,
  output logic             frame_done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-2:0] rx_shift;
  logic [WIDTH-1:0] tx_shift;
  logic [WIDTH-1:0] buf_data;
  logic             buf_full;

  logic frame_start, frame_end, rx_step, tx_step;
  logic tx_load, tx_adv, buf_wr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Priority inside a frame: cs_rise, then restart, then RX edge, then TX edge.
  always_comb begin
    state_nxt   = state;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    rx_step     = 1'b0;
    tx_step     = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall) begin
          state_nxt   = ACTIVE;
          frame_start = 1'b1;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_nxt = IDLE;
          frame_end = 1'b1;
        end else if (cs_fall) begin
          frame_start = 1'b1;
        end else if (sclk_pos) begin
          rx_step = 1'b1;
        end else if (sclk_neg) begin
          tx_step = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign tx_load  = frame_start || (tx_step && cnt == '0);
  assign tx_adv   = tx_step && cnt != '0;
  assign buf_wr   = tx_valid && !buf_full;
  assign tx_ready = !buf_full;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt         <= '0;
      rx_shift    <= '0;
      tx_shift    <= '0;
      buf_data    <= '0;
      buf_full    <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      miso        <= 1'b0;
      miso_oe     <= 1'b0;
      tx_underrun <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      frame_done  <= 1'b0;

      if (frame_start) begin
        cnt     <= '0;
        miso_oe <= 1'b1;
      end

      // Partial RX word is simply abandoned; the counter reset discards it.
      if (frame_end) begin
        cnt        <= '0;
        miso_oe    <= 1'b0;
        frame_done <= 1'b1;
      end

      if (rx_step) begin
        rx_shift <= {rx_shift[WIDTH-3:0], mosi};
        if (cnt == LAST) begin
          rx_data  <= {rx_shift, mosi};
          rx_valid <= 1'b1;
          cnt      <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end

      if (tx_load) begin
        if (buf_full) begin
          tx_shift <= buf_data;
          miso     <= buf_data[WIDTH-1];
          buf_full <= 1'b0;
        end else begin
          tx_shift    <= IDLE_WORD;
          miso        <= IDLE_WORD[WIDTH-1];
          tx_underrun <= 1'b1;
        end
      end

      if (tx_adv) begin
        tx_shift <= {tx_shift[WIDTH-2:0], 1'b0};
        miso     <= tx_shift[WIDTH-2];
      end

      // A write racing an empty-buffer load lands after the idle word is taken.
      if (buf_wr) begin
        buf_data <= tx_data;
        buf_full <= 1'b1;
      end
    end
  end

endmodule
